// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle between the fetch sequencer, instruction memory and execute.
// master: fetch_sequencer side; slave: memory/execute side.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic              program_sel;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;
  logic              halt_req;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] instrucao;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] instr_pc;
  logic              busy;
  logic              halted;
  logic              fault;

  modport master (
    input  start, program_sel, stall, redirect, redirect_target, halt_req, instrucao,
    output address, instr, instr_valid, instr_pc, busy, halted, fault
  );

  modport slave (
    output start, program_sel, stall, redirect, redirect_target, halt_req, instrucao,
    input  address, instr, instr_valid, instr_pc, busy, halted, fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-fetch controller: sequences the PC, resolves absolute jumps locally and
// issues instructions to execute. Optional FETCH_BOUNDS_CHECK_EN halts with fault past MEM_LAST.
module fetch_sequencer #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PROG0_BASE = 0,
  parameter int unsigned PROG1_BASE = 15,
`ifdef FETCH_BOUNDS_CHECK_EN
  parameter int unsigned MEM_LAST   = 80,
`endif
  parameter logic [5:0]  JUMP_OPC   = 6'b010000
) (
  input logic               clock,
  input logic               reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_entry;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_instr_valid;
  logic              r_busy;
  logic              r_halted;
  logic              w_busy_next;
  logic              w_capture;
  logic              w_fault_next;
  logic              r_fault;

  assign w_entry = bus.program_sel ? ADDR_W'(PROG1_BASE) : ADDR_W'(PROG0_BASE);

  // Next-state, next-PC and fault decision
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_fault_next = r_fault;
    w_target     = r_pc + ADDR_W'(1);
    if (bus.redirect) begin
      w_target = bus.redirect_target;
    end else if (r_instr[31:26] == JUMP_OPC) begin
      w_target = r_instr[ADDR_W-1:0];
    end

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_pc_next    = w_entry;
          w_state_next = S_ADDR;
        end
      end
      S_ADDR: begin
        w_state_next = bus.halt_req ? S_HALT : S_WAIT;
      end
      S_WAIT: begin
        w_state_next = bus.halt_req ? S_HALT : S_ISSUE;
      end
      S_ISSUE: begin
        if (bus.halt_req) begin
          w_state_next = S_HALT;
        end else if (!bus.stall) begin
`ifdef FETCH_BOUNDS_CHECK_EN
          if (w_target > ADDR_W'(MEM_LAST)) begin
            w_state_next = S_HALT;
            w_fault_next = 1'b1;
          end else begin
            w_pc_next    = w_target;
            w_state_next = S_ADDR;
          end
`else
          w_pc_next    = w_target;
          w_state_next = S_ADDR;
`endif
        end
      end
      S_HALT: begin
        if (bus.start) begin
          w_pc_next    = w_entry;
          w_fault_next = 1'b0;
          w_state_next = S_ADDR;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_busy_next = (w_state_next == S_ADDR) || (w_state_next == S_WAIT) ||
                       (w_state_next == S_ISSUE);
  assign w_capture   = (r_state == S_WAIT) && (w_state_next == S_ISSUE);

  // State and registered outputs; outputs are precomputed from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_address     <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_address     <= w_busy_next ? w_pc_next : '0;
      r_instr_valid <= (w_state_next == S_ISSUE);
      r_busy        <= w_busy_next;
      r_halted      <= (w_state_next == S_HALT);
      r_fault       <= w_fault_next;
      if (w_capture) begin
        r_instr    <= bus.instrucao;
        r_instr_pc <= r_pc;
      end
    end
  end

  assign bus.address     = r_address;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.busy        = r_busy;
  assign bus.halted      = r_halted;
`ifdef FETCH_BOUNDS_CHECK_EN
  assign bus.fault       = r_fault;
`else
  assign bus.fault       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a one-cycle registered instruction memory model.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mem [1024];
  int          n_vec = 0;
  int          n_err = 0;

  fetch_sequencer_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  fetch_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  always @(posedge clock) bus.instrucao <= mem[bus.address];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (n < 8) begin
      step();
      n++;
      if (bus.instr_valid === 1'b1) break;
    end
    check(tag, 32'(bus.instr_valid), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"},  32'(bus.address), 32'd0);
    check({tag, "_instr"}, bus.instr, 32'd0);
    check({tag, "_ipc"},   32'(bus.instr_pc), 32'd0);
    check({tag, "_flags"}, {28'd0, bus.instr_valid, bus.busy, bus.halted, bus.fault}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0400_0000 | 32'(i);
    mem[0]  = 32'hA81E_0000;
    mem[23] = 32'h4000_0014;

    reset = 1'b1;
    bus.start = 1'b0;
    bus.program_sel = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = '0;
    bus.halt_req = 1'b0;
    step();
    step();
    check_zero("reset");

    // Program 0 from IDLE
    reset = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("c1_addr", 32'(bus.address), 32'd0);
    check("c1_busy", {bus.busy, bus.instr_valid}, 32'b10);
    step();
    check("c2_valid", 32'(bus.instr_valid), 32'd0);
    step();
    check("c3_valid", 32'(bus.instr_valid), 32'd1);
    check("c3_ipc", 32'(bus.instr_pc), 32'd0);
    check("c3_instr", bus.instr, 32'hA81E_0000);
    step();
    check("c4_addr", 32'(bus.address), 32'd1);
    check("c4_valid", 32'(bus.instr_valid), 32'd0);
    step();
    step();
    check("c6_ipc", 32'(bus.instr_pc), 32'd1);
    step();
    check("c7_addr", 32'(bus.address), 32'd2);
    step();
    step();
    check("c9_ipc", 32'(bus.instr_pc), 32'd2);

    // Stall for 4 cycles in ISSUE
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_valid", 32'(bus.instr_valid), 32'd1);
      check("stall_ipc", 32'(bus.instr_pc), 32'd2);
      check("stall_instr", bus.instr, mem[2]);
      check("stall_addr", 32'(bus.address), 32'd2);
    end
    bus.stall = 1'b0;
    step();
    check("rel_addr", 32'(bus.address), 32'd3);
    check("rel_valid", 32'(bus.instr_valid), 32'd0);

    // Halt during ADDR
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;
    check("haddr_flags", {bus.busy, bus.halted, bus.instr_valid}, 32'b010);
    check("haddr_addr", 32'(bus.address), 32'd0);

    // Program 1 from HALT, run up to the local jump at 23
    bus.start = 1'b1;
    bus.program_sel = 1'b1;
    step();
    bus.start = 1'b0;
    check("p1_addr", 32'(bus.address), 32'd15);
    check("p1_halted", 32'(bus.halted), 32'd0);
    for (int pc = 15; pc <= 23; pc++) begin
      wait_valid("p1_wait");
      check("p1_ipc", 32'(bus.instr_pc), 32'(pc));
    end
    check("p1_jinstr", bus.instr, 32'h4000_0014);
    step();
    check("jump_addr", 32'(bus.address), 32'd20);
    for (int pc = 20; pc <= 23; pc++) begin
      wait_valid("loop_wait");
      check("loop_ipc", 32'(bus.instr_pc), 32'(pc));
    end

    // Redirect beats local jump
    bus.redirect = 1'b1;
    bus.redirect_target = 10'd21;
    step();
    bus.redirect = 1'b0;
    check("redir_addr", 32'(bus.address), 32'd21);
    for (int pc = 21; pc <= 23; pc++) begin
      wait_valid("redir_wait");
      check("redir_ipc", 32'(bus.instr_pc), 32'(pc));
    end

    // Halt beats redirect
    bus.redirect = 1'b1;
    bus.halt_req = 1'b1;
    step();
    bus.redirect = 1'b0;
    bus.halt_req = 1'b0;
    check("hiss_flags", {bus.busy, bus.halted, bus.instr_valid}, 32'b010);

    // Bounds: redirect to MEM_LAST, then accept the following pc+1
    bus.start = 1'b1;
    bus.program_sel = 1'b0;
    step();
    bus.start = 1'b0;
    wait_valid("b_wait0");
    bus.redirect = 1'b1;
    bus.redirect_target = 10'd80;
    step();
    bus.redirect = 1'b0;
    check("b_addr80", 32'(bus.address), 32'd80);
    wait_valid("b_wait80");
    check("b_ipc80", 32'(bus.instr_pc), 32'd80);
    step();
`ifdef FETCH_BOUNDS_CHECK_EN
    check("b_fault", {bus.fault, bus.halted, bus.busy}, 32'b110);
    for (int i = 0; i < 4; i++) begin
      check("b_no81", 32'(bus.address == 10'd81), 32'd0);
      step();
    end
    check("b_fault_hold", 32'(bus.fault), 32'd1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("b_fault_clr", 32'(bus.fault), 32'd0);
    check("b_restart", 32'(bus.address), 32'd0);
`else
    check("b_addr81", 32'(bus.address), 32'd81);
    check("b_nofault", 32'(bus.fault), 32'd0);
    wait_valid("b_wait81");
    check("b_instr81", bus.instr, mem[81]);
    bus.redirect = 1'b1;
    bus.redirect_target = 10'd1023;
    step();
    bus.redirect = 1'b0;
    check("w_addr1023", 32'(bus.address), 32'd1023);
    wait_valid("w_wait");
    step();
    check("w_wrap", 32'(bus.address), 32'd0);
`endif

    // Reset during WAIT
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.start = 1'b1;
    bus.program_sel = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_zero("rwait");
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("rs_addr", 32'(bus.address), 32'd15);
    wait_valid("rs_wait");
    check("rs_ipc", 32'(bus.instr_pc), 32'd15);
    check("rs_instr", bus.instr, mem[15]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
